// File: rtl/piso_shift_register_if.sv
// Parallel-load / serial-out bundle for piso_shift_register.
// master = word producer and serial consumer side, slave = the shifter.
interface piso_shift_register_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] Pin;
   logic             Load;
   logic             Ready;
   logic             Sout;
   logic             Sout_Valid;
   logic             Sout_Last;

   modport master (
      output Pin,
      output Load,
      input  Ready,
      input  Sout,
      input  Sout_Valid,
      input  Sout_Last
   );

   modport slave (
      input  Pin,
      input  Load,
      output Ready,
      output Sout,
      output Sout_Valid,
      output Sout_Last
   );
endinterface

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shifter with valid/last framing and back-to-back streaming.
// Optional macro PISO_PARITY_EN appends one even-parity bit to every frame.
module piso_shift_register #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic                   Clock,
   input logic                   Clear,
   piso_shift_register_if.slave  bus
);

`ifdef PISO_PARITY_EN
   localparam int unsigned FrameLen = WIDTH + 1;
`else
   localparam int unsigned FrameLen = WIDTH;
`endif
   localparam int unsigned CntW = $clog2(FrameLen + 1);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StShift = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [CntW-1:0]  cnt_inc;
   logic             sout_q, sout_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             ready;
   logic             accept;
`ifdef PISO_PARITY_EN
   logic             parity_q, parity_d;
`endif

   // Ready reopens while the final frame bit is on the wire so frames can abut.
   assign ready          = (state_q == StIdle) || last_q;
   assign accept         = bus.Load && ready;
   assign cnt_inc        = cnt_q + CntW'(1);

   assign bus.Ready      = ready;
   assign bus.Sout       = sout_q;
   assign bus.Sout_Valid = valid_q;
   assign bus.Sout_Last  = last_q;

   always_comb begin
      state_d  = state_q;
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      sout_d   = sout_q;
      valid_d  = valid_q;
      last_d   = last_q;
`ifdef PISO_PARITY_EN
      parity_d = parity_q;
`endif
      if (accept) begin
         state_d = StShift;
         cnt_d   = '0;
         valid_d = 1'b1;
         last_d  = 1'b0;
         if (MSB_FIRST) begin
            sout_d = bus.Pin[WIDTH-1];
            sreg_d = {bus.Pin[WIDTH-2:0], 1'b0};
         end else begin
            sout_d = bus.Pin[0];
            sreg_d = {1'b0, bus.Pin[WIDTH-1:1]};
         end
`ifdef PISO_PARITY_EN
         parity_d = ^bus.Pin;
`endif
      end else if (state_q == StShift) begin
         if (last_q) begin
            state_d = StIdle;
            sreg_d  = '0;
            cnt_d   = '0;
            sout_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end else begin
            cnt_d  = cnt_inc;
            last_d = (cnt_inc == CntW'(FrameLen - 1));
            if (MSB_FIRST) begin
               sout_d = sreg_q[WIDTH-1];
               sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            end else begin
               sout_d = sreg_q[0];
               sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            end
`ifdef PISO_PARITY_EN
            // Data is exhausted once the counter passes the last data bit index.
            if (cnt_inc == CntW'(WIDTH)) begin
               sout_d = parity_q;
            end
`endif
         end
      end
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_q  <= StIdle;
         sreg_q   <= '0;
         cnt_q    <= '0;
         sout_q   <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
         sout_q   <= sout_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
`ifdef PISO_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_piso_shift_register.sv
// Drives one MSB-first and one LSB-first shifter with identical words and compares
// both against a queue-of-frame-bits reference model.
module tb_piso_shift_register;

   localparam int unsigned W = 4;

   typedef struct packed {
      logic b_msb;
      logic b_lsb;
      logic last;
   } item_t;

   logic Clock;
   logic Clear;

   piso_shift_register_if #(.WIDTH(W)) m_if ();
   piso_shift_register_if #(.WIDTH(W)) l_if ();

   piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (m_if.slave)
   );

   piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (l_if.slave)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int    n_checks = 0;
   int    n_pass   = 0;
   item_t q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Frame for a word: data bits in each order, then optional parity; last flag on the end.
   task automatic load_frame(input logic [W-1:0] pin);
      int n;
      item_t it;
      q.delete();
`ifdef PISO_PARITY_EN
      n = W + 1;
`else
      n = W;
`endif
      for (int i = 0; i < n; i++) begin
         if (i < W) begin
            it.b_msb = pin[W-1-i];
            it.b_lsb = pin[i];
         end else begin
            it.b_msb = ^pin;
            it.b_lsb = ^pin;
         end
         it.last = (i == n - 1);
         q.push_back(it);
      end
   endtask

   task automatic check_outputs();
      logic rdy;
      rdy = (q.size() == 0) || q[0].last;
      check("ready_msb", 32'(m_if.Ready), 32'(rdy));
      check("ready_lsb", 32'(l_if.Ready), 32'(rdy));
      if (q.size() == 0) begin
         check("valid_msb", 32'(m_if.Sout_Valid), 32'd0);
         check("valid_lsb", 32'(l_if.Sout_Valid), 32'd0);
         check("sout_msb",  32'(m_if.Sout),       32'd0);
         check("sout_lsb",  32'(l_if.Sout),       32'd0);
         check("last_msb",  32'(m_if.Sout_Last),  32'd0);
         check("last_lsb",  32'(l_if.Sout_Last),  32'd0);
      end else begin
         check("valid_msb", 32'(m_if.Sout_Valid), 32'd1);
         check("valid_lsb", 32'(l_if.Sout_Valid), 32'd1);
         check("sout_msb",  32'(m_if.Sout),       32'(q[0].b_msb));
         check("sout_lsb",  32'(l_if.Sout),       32'(q[0].b_lsb));
         check("last_msb",  32'(m_if.Sout_Last),  32'(q[0].last));
         check("last_lsb",  32'(l_if.Sout_Last),  32'(q[0].last));
      end
   endtask

   task automatic check_cleared();
      check("rst_sout_msb",  32'(m_if.Sout),       32'd0);
      check("rst_sout_lsb",  32'(l_if.Sout),       32'd0);
      check("rst_valid_msb", 32'(m_if.Sout_Valid), 32'd0);
      check("rst_valid_lsb", 32'(l_if.Sout_Valid), 32'd0);
      check("rst_last_msb",  32'(m_if.Sout_Last),  32'd0);
      check("rst_last_lsb",  32'(l_if.Sout_Last),  32'd0);
   endtask

   // Directed prologue: {reset, load, pin[3:0]} per cycle.
   logic [5:0] dir [0:29] = '{
      6'b01_1011, 6'b00_0000, 6'b00_0000, 6'b00_0000, 6'b00_0000, 6'b00_0000,
      6'b01_1011, 6'b01_1011, 6'b01_1011, 6'b01_0110, 6'b01_0110, 6'b01_0110,
      6'b01_0110, 6'b01_0110, 6'b00_0000, 6'b00_0000,
      6'b01_1100, 6'b00_1111, 6'b01_0011, 6'b00_0011, 6'b00_0000, 6'b00_0000,
      6'b01_1011, 6'b00_0000, 6'b10_0000, 6'b01_0101, 6'b00_0000, 6'b00_0000,
      6'b00_0000, 6'b00_0000
   };

   initial begin
      logic         ld;
      logic [W-1:0] pin;
      logic         rst;
      logic         rdy;

      Clear     = 1'b0;
      m_if.Load = 1'b0;
      l_if.Load = 1'b0;
      m_if.Pin  = '0;
      l_if.Pin  = '0;
      #1;
      check_cleared();
      repeat (2) @(negedge Clock);

      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge Clock);
         if (!Clear) Clear = 1'b1;
         check_outputs();

         if (cyc < 30) begin
            rst = dir[cyc][5];
            ld  = dir[cyc][4];
            pin = dir[cyc][3:0];
         end else begin
            rst = ($urandom_range(0, 99) < 3);
            ld  = ($urandom_range(0, 99) < 60);
            pin = W'($urandom);
         end

         m_if.Load = ld;
         l_if.Load = ld;
         m_if.Pin  = pin;
         l_if.Pin  = pin;

         if (rst) begin
            #2;
            Clear = 1'b0;
            #1;
            check_cleared();
            q.delete();
         end else begin
            rdy = (q.size() == 0) || q[0].last;
            if (rdy && ld) load_frame(pin);
            else if (q.size() != 0) void'(q.pop_front());
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/piso_shift_register.md
Name: piso_shift_register

Overview:
- Parallel-in serial-out shifter, the transmit-side counterpart of the team's 4-bit SIPO shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per Clock on Sout.
- A qualifying valid and last-bit marker go with each bit so a downstream SIPO, or a checker, can frame words.
- Sits between a parallel producer (register file or FIFO) and a single-wire serial link.

Parameters:
WIDTH, 4, data word width in bits; legal range 2..32
MSB_FIRST, 1, 1 = Pin[WIDTH-1] is sent first; 0 = Pin[0] is sent first

Ports:
Clock  input  1  rising-edge clock
Clear  input  1  asynchronous active-low reset; 0 clears all state immediately
Pin  input  WIDTH  parallel word to transmit; sampled only on an accepted load
Load  input  1  producer valid; word is accepted on a Clock edge where Load=1 and Ready=1
Ready  output  1  combinational; block can accept a word this cycle
Sout  output  1  registered serial data bit
Sout_Valid  output  1  registered; 1 while Sout carries a frame bit
Sout_Last  output  1  registered; 1 while Sout carries the final bit of a frame

Behaviour:
- Reset (Clear=0, asynchronous): state=IDLE, shift register=0, bit counter=0, Sout=0, Sout_Valid=0, Sout_Last=0. Ready=1 once Clear=1.
- Any frame in progress is aborted by reset. No partial bits are emitted after Clear deasserts.
- FSM states:
  - IDLE: Ready=1.
  - SHIFT: Ready=1 only while the final frame bit is on Sout (Sout_Last=1); otherwise 0.
- Accept edge (Load=1 and Ready=1):
  - Pin is captured.
  - The first bit appears on Sout at this same edge, with Sout_Valid=1.
  - Bit counter is set to 0; state goes to SHIFT.
  - Latency from accept edge to first valid bit: 0 cycles after the edge (the bit is registered at it).
- In SHIFT, each edge without a new accept does the following:
  - Shifts the next bit onto Sout and increments the counter.
  - Sout_Last=1 when the counter reaches FRAME_LEN-1, where FRAME_LEN=WIDTH (see Optional Feature).
- Edge with Sout_Last=1:
  - If Load=1: the new word is accepted and its first bit follows with no gap (back-to-back streaming, Sout_Valid stays 1).
  - If Load=0: go to IDLE; Sout=0, Sout_Valid=0, Sout_Last=0.
- Load=1 while Ready=0 is ignored. Pin is not sampled, the frame in flight is undisturbed, and the producer must hold Load.
- Pin changes while not accepting have no effect.
- Bit order:
  - MSB_FIRST=1: shift left, Sout = reg[WIDTH-1].
  - MSB_FIRST=0: shift right, Sout = reg[0].
- Vacated shift-register bits fill with 0.
- Counter width is clog2(FRAME_LEN+1). The counter never wraps within a frame; it is reloaded to 0 on each accept.
- Exactly FRAME_LEN valid bits per accepted word. Each frame has exactly one Sout_Last cycle.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - FRAME_LEN=WIDTH+1.
  - After the last data bit, one even-parity bit (XOR of the captured word) is emitted with Sout_Valid=1 and Sout_Last=1.
  - Sout_Last is not asserted on the last data bit.
  - Ready opens only during the parity-bit cycle.
- Undefined: FRAME_LEN=WIDTH; no parity logic or parity state is synthesized.

Test Plan:
- Single word, WIDTH=4, MSB_FIRST=1, Pin=4'b1011 accepted:
  - Sout=1,0,1,1 on the next 4 cycles with Sout_Valid=1.
  - Sout_Last=1 only on the 4th bit.
  - Then Sout_Valid=0 and Ready=1.
- Bit order, MSB_FIRST=0, Pin=4'b1011: Sout=1,1,0,1; Sout_Last on the 4th bit.
- Back-to-back: Load held high with 4'b1011 then 4'b0110 (MSB first):
  - 8 contiguous valid bits 1,0,1,1,0,1,1,0.
  - Sout_Last on bits 4 and 8.
  - Ready=1 only in IDLE and during bits 4 and 8.
- Busy ignore: accept 4'b1100, then pulse Load with Pin=4'b0011 during bit 2:
  - Output remains 1,1,0,0.
  - Second word is not sent unless Load is still high when Ready=1.
- Reset mid-frame: drive Clear=0 during bit 2 of 4'b1011:
  - Sout, Sout_Valid and Sout_Last go to 0 immediately, without waiting for a Clock edge.
  - After Clear=1: Ready=1, no residual bits, and a fresh 4'b0101 is sent cleanly as 0,1,0,1.
- PISO_PARITY_EN defined, Pin=4'b1011: Sout=1,0,1,1,1 (parity=1); Sout_Last only on the 5th bit.
